// File: rtl/matmul_pkg.sv
// Shared types and sizing for the matrix-multiply sequencer slice.
// Holds the FSM state encoding, the pass configuration record and default widths.
package matmul_pkg;

    localparam int ADDR_W = 16;
    localparam int DIM_W  = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FINISH
    } seq_state_t;

    typedef struct packed {
        logic [DIM_W-1:0]  m;
        logic [DIM_W-1:0]  k;
        logic [DIM_W-1:0]  n;
        logic              b_transpose;
        logic [ADDR_W-1:0] a_base;
        logic [ADDR_W-1:0] b_base;
        logic [ADDR_W-1:0] c_base;
    } mm_cfg_t;

    function automatic logic any_zero_dim(input mm_cfg_t c);
        return (c.m == '0) || (c.k == '0) || (c.n == '0);
    endfunction

endpackage

// File: rtl/matmul_sequencer_if.sv
// Start/done handshake, pass configuration and SRAM/MAC strobes of the sequencer.
// The pass scheduler is the master; the sequencer is the slave.
interface matmul_sequencer_if
    import matmul_pkg::*;
();
    logic              start;
    logic [DIM_W-1:0]  cfg_m;
    logic [DIM_W-1:0]  cfg_k;
    logic [DIM_W-1:0]  cfg_n;
    logic              cfg_b_transpose;
    logic [ADDR_W-1:0] cfg_a_base;
    logic [ADDR_W-1:0] cfg_b_base;
    logic [ADDR_W-1:0] cfg_c_base;

    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] a_rd_addr;
    logic [ADDR_W-1:0] b_rd_addr;
    logic              mac_en;
    logic              mac_clear;
    logic              c_wr_en;
    logic [ADDR_W-1:0] c_wr_addr;

    modport master (
        output start, cfg_m, cfg_k, cfg_n, cfg_b_transpose, cfg_a_base, cfg_b_base, cfg_c_base,
        input  busy, done, a_rd_addr, b_rd_addr, mac_en, mac_clear, c_wr_en, c_wr_addr
    );

    modport slave (
        input  start, cfg_m, cfg_k, cfg_n, cfg_b_transpose, cfg_a_base, cfg_b_base, cfg_c_base,
        output busy, done, a_rd_addr, b_rd_addr, mac_en, mac_clear, c_wr_en, c_wr_addr
    );
endinterface

// File: rtl/matseq_loop_counter.sv
// Nested i (row) / j (column) / k (inner) counters for one matmul pass.
// Flags describe the index triple currently being issued; wrap strobes steer the pointer adders.
module matseq_loop_counter
    import matmul_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_clear,
    input  logic             i_advance,
    input  logic [DIM_W-1:0] i_dim_m,
    input  logic [DIM_W-1:0] i_dim_k,
    input  logic [DIM_W-1:0] i_dim_n,
    output logic             o_k_first,
    output logic             o_k_last,
    output logic             o_last_iter,
    output logic             o_k_wrap,
    output logic             o_j_wrap
);
    logic [DIM_W-1:0] r_i, r_j, r_k;
    logic             w_i_last, w_j_last, w_k_last;

    assign w_i_last    = (r_i == i_dim_m - DIM_W'(1));
    assign w_j_last    = (r_j == i_dim_n - DIM_W'(1));
    assign w_k_last    = (r_k == i_dim_k - DIM_W'(1));
    assign o_k_first   = (r_k == '0);
    assign o_k_last    = w_k_last;
    assign o_last_iter = w_i_last && w_j_last && w_k_last;
    assign o_k_wrap    = i_advance && w_k_last;
    assign o_j_wrap    = i_advance && w_k_last && w_j_last;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_i <= '0;
            r_j <= '0;
            r_k <= '0;
        end else if (i_clear) begin
            r_i <= '0;
            r_j <= '0;
            r_k <= '0;
        end else if (i_advance) begin
            if (w_k_last) begin
                r_k <= '0;
                if (w_j_last) begin
                    r_j <= '0;
                    r_i <= r_i + DIM_W'(1);
                end else begin
                    r_j <= r_j + DIM_W'(1);
                end
            end else begin
                r_k <= r_k + DIM_W'(1);
            end
        end
    end
endmodule

// File: rtl/matmul_sequencer.sv
// Address/strobe sequencer for one C = A x B (or A x B^T) pass on the single-MAC datapath.
// Pointers advance by addition only; MAC/write strobes trail the addresses by the 1-cycle SRAM latency.
module matmul_sequencer
    import matmul_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    matmul_sequencer_if.slave  bus
);
    seq_state_t        r_state, w_next_state;
    mm_cfg_t           w_cfg_in;
    logic              w_accept, w_zero_dim, w_advance;
    logic              w_k_first, w_k_last, w_last_iter, w_k_wrap, w_j_wrap;

    logic [DIM_W-1:0]  r_m, r_k, r_n;
    logic              r_b_transpose;
    logic [ADDR_W-1:0] r_b_base;
    logic [ADDR_W-1:0] r_a_addr, r_a_row, r_b_addr, r_b_col, r_c_ptr;
    logic              r_busy, r_done, r_mac_en, r_mac_clear, r_c_wr_en;
    logic [ADDR_W-1:0] r_c_wr_addr;

    assign w_cfg_in = '{m: bus.cfg_m, k: bus.cfg_k, n: bus.cfg_n,
                        b_transpose: bus.cfg_b_transpose, a_base: bus.cfg_a_base,
                        b_base: bus.cfg_b_base, c_base: bus.cfg_c_base};
    assign w_accept   = (r_state == IDLE) && bus.start;
    assign w_zero_dim = any_zero_dim(w_cfg_in);
    assign w_advance  = (r_state == RUN) && !w_last_iter;

    matseq_loop_counter u_loop (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_clear    (w_accept),
        .i_advance  (w_advance),
        .i_dim_m    (r_m),
        .i_dim_k    (r_k),
        .i_dim_n    (r_n),
        .o_k_first  (w_k_first),
        .o_k_last   (w_k_last),
        .o_last_iter(w_last_iter),
        .o_k_wrap   (w_k_wrap),
        .o_j_wrap   (w_j_wrap)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next_state;
    end

    // NOTE: the next state is defaulted before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next_state = w_zero_dim ? FINISH : RUN;
            RUN:     if (w_last_iter) w_next_state = DRAIN;
            DRAIN:   w_next_state = FINISH;
            FINISH:  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_m           <= '0;
            r_k           <= '0;
            r_n           <= '0;
            r_b_transpose <= 1'b0;
            r_b_base      <= '0;
        end else if (w_accept) begin
            r_m           <= w_cfg_in.m;
            r_k           <= w_cfg_in.k;
            r_n           <= w_cfg_in.n;
            r_b_transpose <= w_cfg_in.b_transpose;
            r_b_base      <= w_cfg_in.b_base;
        end
    end

    // a_row/b_col remember where the current row of A / column of B starts,
    // so a k wrap can rewind without a multiply.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a_addr <= '0;
            r_a_row  <= '0;
            r_b_addr <= '0;
            r_b_col  <= '0;
            r_c_ptr  <= '0;
        end else if (w_accept && !w_zero_dim) begin
            r_a_addr <= w_cfg_in.a_base;
            r_a_row  <= w_cfg_in.a_base;
            r_b_addr <= w_cfg_in.b_base;
            r_b_col  <= w_cfg_in.b_base;
            r_c_ptr  <= w_cfg_in.c_base;
        end else if (w_advance) begin
            if (w_j_wrap) begin
                r_a_addr <= r_a_addr + ADDR_W'(1);
                r_a_row  <= r_a_addr + ADDR_W'(1);
            end else if (w_k_wrap) begin
                r_a_addr <= r_a_row;
            end else begin
                r_a_addr <= r_a_addr + ADDR_W'(1);
            end

            if (w_j_wrap) begin
                r_b_addr <= r_b_base;
                r_b_col  <= r_b_base;
            end else if (r_b_transpose) begin
                r_b_addr <= r_b_addr + ADDR_W'(1);
            end else if (w_k_wrap) begin
                r_b_addr <= r_b_col + ADDR_W'(1);
                r_b_col  <= r_b_col + ADDR_W'(1);
            end else begin
                r_b_addr <= r_b_addr + ADDR_W'(r_n);
            end

            if (w_k_wrap) r_c_ptr <= r_c_ptr + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_mac_en    <= 1'b0;
            r_mac_clear <= 1'b0;
            r_c_wr_en   <= 1'b0;
            r_c_wr_addr <= '0;
        end else begin
            r_busy      <= (w_next_state == RUN) || (w_next_state == DRAIN);
            r_done      <= (w_next_state == FINISH);
            r_mac_en    <= (r_state == RUN);
            r_mac_clear <= (r_state == RUN) && w_k_first;
            r_c_wr_en   <= (r_state == RUN) && w_k_last;
            if ((r_state == RUN) && w_k_last) r_c_wr_addr <= r_c_ptr;
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.a_rd_addr = r_a_addr;
    assign bus.b_rd_addr = r_b_addr;
    assign bus.mac_en    = r_mac_en;
    assign bus.mac_clear = r_mac_clear;
    assign bus.c_wr_en   = r_c_wr_en;
    assign bus.c_wr_addr = r_c_wr_addr;
endmodule

// File: tb/tb_matmul_sequencer.sv
// Scoreboard bench for matmul_sequencer: a loop-nest reference model queues every expected
// MAC/write event and done cycle; a negedge monitor pops and compares as the DUT emits them.
module tb_matmul_sequencer;
    import matmul_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    matmul_sequencer_if bus ();

    matmul_sequencer dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    typedef struct {
        int                cyc;
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] b;
        bit                clr;
        bit                wr;
        logic [ADDR_W-1:0] waddr;
    } mac_exp_t;

    mac_exp_t          mac_q[$];
    int                done_q[$];
    int                cyc = 0;
    int                n_checks = 0;
    int                n_errors = 0;
    logic [ADDR_W-1:0] prev_a = '0;
    logic [ADDR_W-1:0] prev_b = '0;
    mac_exp_t          mon_e;
    int                mon_d;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got event expected none (cycle %0d)", name, cyc);
    endtask

    // Monitor: the address pair seen one cycle before each mac_en is the pair being consumed.
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.mac_en) begin
                if (mac_q.size() == 0) flag("stray_mac");
                else begin
                    mon_e = mac_q.pop_front();
                    check("mac_cycle", cyc, mon_e.cyc);
                    check("a_rd_addr", 32'(prev_a), 32'(mon_e.a));
                    check("b_rd_addr", 32'(prev_b), 32'(mon_e.b));
                    check("mac_clear", 32'(bus.mac_clear), 32'(mon_e.clr));
                    check("c_wr_en", 32'(bus.c_wr_en), 32'(mon_e.wr));
                    if (mon_e.wr) check("c_wr_addr", 32'(bus.c_wr_addr), 32'(mon_e.waddr));
                end
            end else if (bus.mac_clear || bus.c_wr_en) begin
                flag("strobe_without_mac");
            end
            if (bus.done) begin
                if (done_q.size() == 0) flag("stray_done");
                else begin
                    mon_d = done_q.pop_front();
                    check("done_cycle", cyc, mon_d);
                    check("busy_at_done", 32'(bus.busy), 32'd0);
                end
            end
        end
        prev_a = bus.a_rd_addr;
        prev_b = bus.b_rd_addr;
    end

    // Reference model: plain nested loops with multiplies, addresses wrapped to ADDR_W.
    task automatic push_model(input mm_cfg_t c, input int c0);
        int mm, kk, nn, idx;
        mm  = int'(c.m);
        kk  = int'(c.k);
        nn  = int'(c.n);
        idx = 0;
        if (mm * kk * nn == 0) begin
            done_q.push_back(c0 + 1);
            return;
        end
        for (int i = 0; i < mm; i++)
            for (int j = 0; j < nn; j++)
                for (int k = 0; k < kk; k++) begin
                    mac_exp_t e;
                    e.cyc   = c0 + 2 + idx;
                    e.a     = ADDR_W'(int'(c.a_base) + i * kk + k);
                    e.b     = c.b_transpose ? ADDR_W'(int'(c.b_base) + j * kk + k)
                                            : ADDR_W'(int'(c.b_base) + k * nn + j);
                    e.clr   = (k == 0);
                    e.wr    = (k == kk - 1);
                    e.waddr = ADDR_W'(int'(c.c_base) + i * nn + j);
                    mac_q.push_back(e);
                    idx++;
                end
        done_q.push_back(c0 + mm * kk * nn + 2);
    endtask

    function automatic mm_cfg_t rand_cfg();
        mm_cfg_t r;
        r.m           = DIM_W'($urandom_range(1, 4));
        r.k           = DIM_W'($urandom_range(1, 4));
        r.n           = DIM_W'($urandom_range(1, 4));
        r.b_transpose = 1'($urandom_range(0, 1));
        r.a_base      = ADDR_W'($urandom);
        r.b_base      = ADDR_W'($urandom);
        r.c_base      = ADDR_W'($urandom);
        return r;
    endfunction

    task automatic drive_cfg(input mm_cfg_t c);
        bus.cfg_m           = c.m;
        bus.cfg_k           = c.k;
        bus.cfg_n           = c.n;
        bus.cfg_b_transpose = c.b_transpose;
        bus.cfg_a_base      = c.a_base;
        bus.cfg_b_base      = c.b_base;
        bus.cfg_c_base      = c.c_base;
    endtask

    task automatic start_pass(input mm_cfg_t c, output int c0);
        @(negedge clk);
        #1;
        drive_cfg(c);
        bus.start = 1'b1;
        c0 = cyc;
        push_model(c, c0);
    endtask

    // extra_at > 0 raises a second, ignored start at that cycle offset from the accepted start.
    task automatic run_pass(input mm_cfg_t c, input int extra_at);
        int c0, budget;
        bit finished;
        finished = 1'b0;
        budget   = int'(c.m) * int'(c.k) * int'(c.n) + 12;
        start_pass(c, c0);
        for (int t = 0; t < budget; t++) begin
            @(negedge clk);
            #1;
            if (bus.start) begin
                bus.start = 1'b0;
                drive_cfg(rand_cfg());
            end
            if (cyc == c0 + 1) check("busy_after_start", 32'(bus.busy), 32'(!any_zero_dim(c)));
            if (extra_at > 0 && cyc == c0 + extra_at) begin
                drive_cfg(rand_cfg());
                bus.start = 1'b1;
            end
            if (mac_q.size() == 0 && done_q.size() == 0) begin
                finished = 1'b1;
                break;
            end
        end
        if (!finished) begin
            flag("pass_timeout");
            mac_q.delete();
            done_q.delete();
        end
        if (bus.start) begin
            @(negedge clk);
            #1;
            bus.start = 1'b0;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_done"}, 32'(bus.done), 32'd0);
        check({tag, "_a_rd_addr"}, 32'(bus.a_rd_addr), 32'd0);
        check({tag, "_b_rd_addr"}, 32'(bus.b_rd_addr), 32'd0);
        check({tag, "_mac_en"}, 32'(bus.mac_en), 32'd0);
        check({tag, "_mac_clear"}, 32'(bus.mac_clear), 32'd0);
        check({tag, "_c_wr_en"}, 32'(bus.c_wr_en), 32'd0);
        check({tag, "_c_wr_addr"}, 32'(bus.c_wr_addr), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        mm_cfg_t basic, c;
        int      c0;

        bus.start = 1'b0;
        drive_cfg('0);
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        reset_n = 1'b1;

        basic = '{m: 8'd2, k: 8'd3, n: 8'd2, b_transpose: 1'b0,
                  a_base: 16'd1, b_base: 16'd1, c_base: 16'd0};
        run_pass(basic, 0);

        c = basic;
        c.b_transpose = 1'b1;
        run_pass(c, 0);

        c = '{m: 8'd1, k: 8'd1, n: 8'd1, b_transpose: 1'b0,
              a_base: 16'd7, b_base: 16'd9, c_base: 16'd20};
        run_pass(c, 0);

        c = basic;
        c.k = 8'd0;
        run_pass(c, 0);

        run_pass(basic, 5);
        run_pass(basic, 14);

        c = '{m: 8'd1, k: 8'd255, n: 8'd2, b_transpose: 1'b0,
              a_base: 16'hFF80, b_base: 16'hFFF0, c_base: 16'hFFFF};
        run_pass(c, 0);

        // Reset in the middle of a pass: everything drops at once and nothing further is expected.
        start_pass(basic, c0);
        for (int t = 0; t < 20 && cyc < c0 + 6; t++) begin
            @(negedge clk);
            #1;
            if (bus.start) bus.start = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        check_outputs_zero("midpass_reset");
        mac_q.delete();
        done_q.delete();
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        run_pass(basic, 0);

        for (int r = 0; r < 12; r++) begin
            c = rand_cfg();
            if ($urandom_range(0, 5) == 0) c.n = 8'd0;
            run_pass(c, ($urandom_range(0, 2) == 0) ? 3 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
